// File: rtl/gate_truth_checker_if.sv
// Signal bundle between gate_truth_checker and the gate under test / controller.
// The first-fail log signals exist only when CHECK_LOG_EN is defined.
interface gate_truth_checker_if #(
  parameter int unsigned ERR_W = 3
);
  logic             start;
  logic             s_i;
  logic             a_o;
  logic             b_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef CHECK_LOG_EN
  logic             first_fail_vld;
  logic [1:0]       first_fail_vec;
`endif

  modport master (
    input  start,
    input  s_i,
    output a_o,
    output b_o,
    output busy,
    output done,
    output pass,
    output err_cnt
`ifdef CHECK_LOG_EN
    ,
    output first_fail_vld,
    output first_fail_vec
`endif
  );

  modport slave (
    output start,
    output s_i,
    input  a_o,
    input  b_o,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt
`ifdef CHECK_LOG_EN
    ,
    input  first_fail_vld,
    input  first_fail_vec
`endif
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps all four (a,b) vectors into a 2-input gate and checks its output against TRUTH.
// Define CHECK_LOG_EN to add first_fail_vld/first_fail_vec (first mismatching vector of a sweep).
//
// state  | meaning
// IDLE   | outputs parked at 0, waiting for start
// DRIVE  | {a_o,b_o}=vec held for SETTLE cycles
// SAMPLE | compare s_i with TRUTH[vec], advance vec
// DONE   | sweep finished; done/pass registered on exit
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  gate_truth_checker_if.master bus
);
  localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             done_q;
  logic             pass_q;
  logic             settled;
  logic             mismatch;

  assign settled  = (cnt == CNT_LAST);
  // Case inequality so an X/Z from the gate under test counts as a failure.
  assign mismatch = (bus.s_i !== TRUTH[vec]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = DRIVE;
      DRIVE:   if (settled) state_nx = SAMPLE;
      SAMPLE:  state_nx = (vec == 2'd3) ? DONE : DRIVE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.a_o  = 1'b0;
    bus.b_o  = 1'b0;
    bus.busy = 1'b0;
    case (state)
      DRIVE, SAMPLE: begin
        bus.a_o  = vec[1];
        bus.b_o  = vec[0];
        bus.busy = 1'b1;
      end
      DONE:    bus.busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec     <= 2'd0;
      cnt     <= '0;
      err_cnt <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec     <= 2'd0;
            cnt     <= '0;
            err_cnt <= '0;
            pass_q  <= 1'b0;
          end
        end
        DRIVE: begin
          cnt <= settled ? '0 : cnt + CNT_W'(1);
        end
        SAMPLE: begin
          if (mismatch && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
          vec <= vec + 2'd1;
        end
        DONE: begin
          done_q <= 1'b1;
          pass_q <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt;

`ifdef CHECK_LOG_EN
  logic       ff_vld;
  logic [1:0] ff_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_vld <= 1'b0;
      ff_vec <= 2'd0;
    end else if ((state == IDLE) && bus.start) begin
      ff_vld <= 1'b0;
      ff_vec <= 2'd0;
    end else if ((state == SAMPLE) && mismatch && !ff_vld) begin
      ff_vld <= 1'b1;
      ff_vec <= vec;
    end
  end

  assign bus.first_fail_vld = ff_vld;
  assign bus.first_fail_vec = ff_vec;
`endif
endmodule
